// File: rtl/vga_capture.sv
// vga_capture: sink end of a VGA timing link. Samples hs/vs/RGB444, recovers the
// raster position, verifies line/frame geometry, locks, and emits frame-buffer
// write strobes for the active window.
// Optional feature: define VGA_CAPTURE_MEAS_EN to add meas_htotal/meas_vtotal,
// the measured incoming line length (clocks) and frame height (lines).
module vga_capture #(
  parameter int unsigned H_SYNC  = 96,
  parameter int unsigned H_BACK  = 48,
  parameter int unsigned H_DISP  = 640,
  parameter int unsigned H_TOTAL = 800,
  parameter int unsigned V_SYNC  = 2,
  parameter int unsigned V_BACK  = 33,
  parameter int unsigned V_DISP  = 480,
  parameter int unsigned V_TOTAL = 525
) (
  input  logic        vga_clk,
  input  logic        sys_rst,
  input  logic        vid_hs,
  input  logic        vid_vs,
  input  logic [11:0] vid_rgb,
  output logic        wr_en,
  output logic [18:0] wr_addr,
  output logic [11:0] wr_data,
  output logic        locked,
  output logic        frame_done,
  output logic        sync_err
`ifdef VGA_CAPTURE_MEAS_EN
  ,
  output logic [9:0]  meas_htotal,
  output logic [9:0]  meas_vtotal
`endif
);

  localparam int unsigned CW = 10;
  localparam int unsigned AW = 19;

  localparam logic [CW-1:0] CNT_MAX  = CW'(1023);
  localparam logic [CW-1:0] H_LAST   = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] V_LAST   = CW'(V_TOTAL - 1);
  localparam logic [CW-1:0] H_ACT_LO = CW'(H_SYNC + H_BACK);
  localparam logic [CW-1:0] H_ACT_HI = CW'(H_SYNC + H_BACK + H_DISP);
  localparam logic [CW-1:0] V_ACT_LO = CW'(V_SYNC + V_BACK);
  localparam logic [CW-1:0] V_ACT_HI = CW'(V_SYNC + V_BACK + V_DISP);
  localparam logic [AW-1:0] ADDR_LAST = AW'(H_DISP * V_DISP - 1);

  typedef enum logic [1:0] {ST_SEARCH, ST_ALIGN, ST_LOCKED} state_t;

  state_t        state_q;
  logic          hs_q, vs_q, hs_p_q, vs_p_q;
  logic [11:0]   rgb_q;
  logic [CW-1:0] hcnt_q, hcnt_d, hcnt_inc;
  logic [CW-1:0] vcnt_q, vcnt_d, vcnt_inc;
  logic          hs_fall, vs_fall, active, line_bad, frame_bad, timeout;
  logic          wr_en_q, locked_q, frame_done_q, sync_err_q;
  logic [AW-1:0] wr_addr_q, wr_addr_d;
  logic [11:0]   wr_data_q;

  // Edge detection, counter next-state and geometry checks.
  // hcnt_d/vcnt_d are the transmitter position of the pixel currently in rgb_q;
  // hcnt_q/vcnt_q still hold the length reached by the previous line/frame.
  always_comb begin
    hs_fall   = hs_p_q & ~hs_q;
    vs_fall   = vs_p_q & ~vs_q;
    hcnt_inc  = (hcnt_q == CNT_MAX) ? CNT_MAX : hcnt_q + CW'(1);
    vcnt_inc  = (vcnt_q == CNT_MAX) ? CNT_MAX : vcnt_q + CW'(1);
    hcnt_d    = hs_fall ? '0 : hcnt_inc;
    vcnt_d    = vcnt_q;
    if (hs_fall) begin
      vcnt_d = vs_fall ? '0 : vcnt_inc;
    end
    active    = (hcnt_d >= H_ACT_LO) && (hcnt_d < H_ACT_HI) &&
                (vcnt_d >= V_ACT_LO) && (vcnt_d < V_ACT_HI);
    line_bad  = hs_fall && (hcnt_q != H_LAST);
    frame_bad = vs_fall && (!hs_fall || (vcnt_q != V_LAST));
    timeout   = (hcnt_q == CNT_MAX);
    wr_addr_d = wr_addr_q;
    if (vs_fall) begin
      wr_addr_d = '0;
    end else if (wr_en_q && (wr_addr_q != ADDR_LAST)) begin
      wr_addr_d = wr_addr_q + AW'(1);
    end
  end

  // Input sampling stage plus one-deep history for edge detection.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      hs_q   <= 1'b1;
      vs_q   <= 1'b1;
      hs_p_q <= 1'b1;
      vs_p_q <= 1'b1;
      rgb_q  <= '0;
    end else begin
      hs_q   <= vid_hs;
      vs_q   <= vid_vs;
      hs_p_q <= hs_q;
      vs_p_q <= vs_q;
      rgb_q  <= vid_rgb;
    end
  end

  // Raster position counters, write address and end-of-frame pulse.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      hcnt_q       <= '0;
      vcnt_q       <= '0;
      wr_addr_q    <= '0;
      frame_done_q <= 1'b0;
    end else begin
      hcnt_q       <= hcnt_d;
      vcnt_q       <= vcnt_d;
      wr_addr_q    <= wr_addr_d;
      frame_done_q <= wr_en_q && (wr_addr_q == ADDR_LAST);
    end
  end

  // Lock FSM with registered write strobe, lock flag and error pulse.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      state_q    <= ST_SEARCH;
      locked_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      wr_data_q  <= '0;
      sync_err_q <= 1'b0;
    end else begin
      wr_en_q    <= 1'b0;
      sync_err_q <= 1'b0;
      case (state_q)
        ST_SEARCH: begin
          if (vs_fall && hs_fall) begin
            state_q <= ST_ALIGN;
          end
        end
        ST_ALIGN: begin
          if (line_bad || timeout) begin
            state_q <= ST_SEARCH;
          end else if (vs_fall && !frame_bad) begin
            state_q  <= ST_LOCKED;
            locked_q <= 1'b1;
          end
        end
        ST_LOCKED: begin
          if (line_bad || frame_bad || timeout) begin
            state_q    <= ST_SEARCH;
            locked_q   <= 1'b0;
            sync_err_q <= 1'b1;
          end else begin
            wr_en_q <= active;
            if (active) begin
              wr_data_q <= rgb_q;
            end
          end
        end
        default: begin
          state_q  <= ST_SEARCH;
          locked_q <= 1'b0;
        end
      endcase
    end
  end

`ifdef VGA_CAPTURE_MEAS_EN
  logic [CW-1:0] meas_htotal_q, meas_vtotal_q;

  // Measured geometry of the incoming stream, updated regardless of lock state.
  always_ff @(posedge vga_clk) begin
    if (sys_rst) begin
      meas_htotal_q <= '0;
      meas_vtotal_q <= '0;
    end else begin
      if (hs_fall) begin
        meas_htotal_q <= hcnt_inc;
      end
      if (vs_fall) begin
        meas_vtotal_q <= vcnt_inc;
      end
    end
  end

  assign meas_htotal = meas_htotal_q;
  assign meas_vtotal = meas_vtotal_q;
`endif

  assign wr_en      = wr_en_q;
  assign wr_addr    = wr_addr_q;
  assign wr_data    = wr_data_q;
  assign locked     = locked_q;
  assign frame_done = frame_done_q;
  assign sync_err   = sync_err_q;

endmodule
